hlsm_launcher: RTL and testbench
================================

# hlsm_launcher

Initiator-side controller for a generated high-level state machine (HLSM) core that uses the Start/Done convention. It accepts operand bundles over a valid/ready stream and drives them onto the HLSM operand inputs. It holds Start for the whole computation, captures the result when Done rises, and returns result, cycle count and error status over a second valid/ready stream. It sits between a host/DMA operand source and one HLSM instance; an optional watchdog recovers a hung core by pulsing the core's reset.

## Interface
Parameters:
- DATA_W, 16, width of each signed operand and of the result
- NUM_OPS, 5, number of operands per bundle
- TIMEOUT, 1023, watchdog limit in cycles spent in WAIT; only used with the timeout feature

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  operand bundle valid
- op_ready  out  1  launcher can accept a bundle
- op_data  in  NUM_OPS*DATA_W  operands; operand k occupies bits [k*DATA_W +: DATA_W]
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_data  out  DATA_W  captured HLSM result
- res_cycles  out  16  cycles from launch to Done; saturates at 16'hFFFF
- res_err  out  1  1 = watchdog timeout; res_data is 0 in that case
- hlsm_start  out  1  Start to HLSM
- hlsm_rst  out  1  reset to HLSM; one-cycle pulse on timeout
- hlsm_ops  out  NUM_OPS*DATA_W  registered operands to HLSM
- hlsm_done  in  1  Done from HLSM
- hlsm_result  in  DATA_W  HLSM result output
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ARM, WAIT, RESP, RECOVER.
- IDLE: op_ready=1. On op_valid&op_ready, latch op_data into hlsm_ops, clear the cycle counter, go to ARM.
- ARM, one cycle: hlsm_start=1. hlsm_done is ignored here because it may still be high from the previous run. Go to WAIT.
- WAIT:
  - hlsm_start = ~hlsm_done. This is combinational, so the HLSM returning to its idle state never relaunches.
  - The cycle counter increments each cycle.
  - On hlsm_done=1: register hlsm_result into res_data, the counter into res_cycles, res_err=0, go to RESP.
- RESP: res_valid=1, and all res_* outputs are held stable. On res_ready, go to IDLE.
- hlsm_ops is held unchanged from latch until the next accepted bundle.
- op_ready is 0 outside IDLE, so only one bundle is in flight.
- res_cycles counts ARM as cycle 1. A Done seen in the first WAIT cycle therefore reports 2.
- Signed data passes through unmodified; the block does no arithmetic on it.

## Timing
- Reset values:
  - state=IDLE; op_ready=1 (combinational from IDLE).
  - res_valid=0, res_data=0, res_cycles=0, res_err=0.
  - hlsm_start=0, hlsm_rst=0, hlsm_ops=0, busy=0.
- Launch latency: acceptance edge → hlsm_start high in the next cycle.
- Done-to-result latency: the edge sampling hlsm_done=1 → res_valid high in the next cycle.
- Minimum overhead per transaction outside HLSM latency: 3 cycles (accept, ARM, RESP).
- Back-pressure: if res_ready stays low, RESP holds indefinitely and op_ready stays 0.
- res_valid and res_ready high in the same cycle: transfer completes; op_ready is 1 in the following cycle.
- Reset mid-operation: returns to IDLE at once. Any pending result is discarded and hlsm_start drops asynchronously.
- hlsm_done glitching high in IDLE, RESP or ARM: ignored.

## Configuration
- HLSM_LAUNCHER_TIMEOUT_EN defined:
  - If the WAIT cycle count reaches TIMEOUT without Done, go to RECOVER.
  - RECOVER, one cycle: hlsm_start=0, hlsm_rst=1.
  - Then RESP with res_err=1, res_data=0, res_cycles=count.
- HLSM_LAUNCHER_TIMEOUT_EN undefined:
  - WAIT waits forever; RECOVER is unreachable.
  - hlsm_rst is tied 0 and res_err is tied 0.
  - res_cycles still counts and saturates.

## Test plan
- Single run: HLSM model computes i=a+b+c+d+e with Done after 11 cycles. Send ops {1,2,3,4,5} → hlsm_start high for 12 cycles, then res_data=15, res_cycles=13, res_err=0, exactly one res_valid transaction.
- Stale Done: HLSM model keeps Done=1 from the prior run until relaunched. Two back-to-back bundles {−7,0,0,0,0} and {100,1,1,1,1} → second run is not short-circuited; results are −7 then 104.
- Back-pressure: hold res_ready=0 for 20 cycles after res_valid → res_data stable, op_ready=0 throughout, op_valid is not accepted; releasing res_ready completes the transfer.
- Timeout (macro defined, TIMEOUT=50): model never asserts Done → hlsm_rst pulses exactly one cycle after 50 WAIT cycles; res_err=1, res_data=0. The next bundle runs normally.
- Async reset asserted mid-WAIT → outputs take reset values without a clock edge; res_valid never asserts for the aborted run.
- Macro undefined: Done withheld for 2000 cycles → no hlsm_rst and no res_valid. Done then arrives → normal result with res_cycles=2001.

Source files
------------

// File: rtl/hlsm_launcher.sv
// hlsm_launcher
// Initiator-side controller for a Start/Done HLSM core. Takes operand bundles
// from a valid/ready stream, launches the core, and returns the core's result,
// the launch-to-Done cycle count and an error flag on a second valid/ready
// stream. Only one bundle is in flight at a time.
//
// Optional feature: define HLSM_LAUNCHER_TIMEOUT_EN to enable the watchdog.
// With it, a core that stays in WAIT for TIMEOUT cycles without Done is reset
// through o_hlsm_rst for one cycle and an error response is returned. Without
// it, WAIT waits forever and o_hlsm_rst / o_res_err are tied low.

module hlsm_launcher #(
  parameter int DATA_W  = 16,
  parameter int NUM_OPS = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_op_valid,
  output logic                      o_op_ready,
  input  logic [NUM_OPS*DATA_W-1:0] i_op_data,
  output logic                      o_res_valid,
  input  logic                      i_res_ready,
  output logic [DATA_W-1:0]         o_res_data,
  output logic [15:0]               o_res_cycles,
  output logic                      o_res_err,
  output logic                      o_hlsm_start,
  output logic                      o_hlsm_rst,
  output logic [NUM_OPS*DATA_W-1:0] o_hlsm_ops,
  input  logic                      i_hlsm_done,
  input  logic [DATA_W-1:0]         i_hlsm_result,
  output logic                      o_busy
);

  localparam int OPS_W = NUM_OPS * DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    RESP,
    RECOVER
  } state_t;

  state_t             r_state;
  logic [OPS_W-1:0]   r_ops;
  logic [15:0]        r_cnt;
  logic [DATA_W-1:0]  r_res_data;
  logic [15:0]        r_res_cycles;
  logic [15:0]        w_cnt_inc;

  // The cycle counter saturates at all-ones so very long runs still report a
  // meaningful (clipped) value instead of wrapping to a small number.
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : (r_cnt + 16'd1);

`ifdef HLSM_LAUNCHER_TIMEOUT_EN
  // The counter value during WAIT cycle k is k (ARM already counted as 1),
  // so comparing it against TIMEOUT gives exactly TIMEOUT WAIT cycles.
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);

  logic r_res_err;

  // Main controller with watchdog: launch, wait for Done or timeout, respond.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_ops        <= '0;
      r_cnt        <= '0;
      r_res_data   <= '0;
      r_res_cycles <= '0;
      r_res_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_op_valid) begin
            r_ops   <= i_op_data;
            r_cnt   <= '0;
            r_state <= ARM;
          end
        end
        ARM: begin
          r_cnt   <= w_cnt_inc;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= w_cnt_inc;
          if (i_hlsm_done) begin
            r_res_data   <= i_hlsm_result;
            r_res_cycles <= w_cnt_inc;
            r_res_err    <= 1'b0;
            r_state      <= RESP;
          end else if (r_cnt >= TIMEOUT_LIM) begin
            r_state <= RECOVER;
          end
        end
        RECOVER: begin
          r_res_data   <= '0;
          r_res_cycles <= r_cnt;
          r_res_err    <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (i_res_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_res_err  = r_res_err;
  assign o_hlsm_rst = (r_state == RECOVER);
`else
  // TIMEOUT only matters for the watchdog build.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);

  // Main controller without watchdog: launch, wait for Done, respond.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_ops        <= '0;
      r_cnt        <= '0;
      r_res_data   <= '0;
      r_res_cycles <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_op_valid) begin
            r_ops   <= i_op_data;
            r_cnt   <= '0;
            r_state <= ARM;
          end
        end
        ARM: begin
          r_cnt   <= w_cnt_inc;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= w_cnt_inc;
          if (i_hlsm_done) begin
            r_res_data   <= i_hlsm_result;
            r_res_cycles <= w_cnt_inc;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (i_res_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_res_err  = 1'b0;
  assign o_hlsm_rst = 1'b0;
`endif

  // Start is held through ARM regardless of Done (a stale Done from the last
  // run may still be high), and in WAIT it drops as soon as Done appears so a
  // core returning to idle is never relaunched. Because it decodes the state
  // register, an async reset removes it immediately.
  assign o_hlsm_start = (r_state == ARM) || ((r_state == WAIT) && !i_hlsm_done);

  assign o_op_ready   = (r_state == IDLE);
  assign o_busy       = (r_state != IDLE);
  assign o_res_valid  = (r_state == RESP);
  assign o_res_data   = r_res_data;
  assign o_res_cycles = r_res_cycles;
  assign o_hlsm_ops   = r_ops;

endmodule

// File: tb/tb_hlsm_launcher.sv
// Testbench for hlsm_launcher: behavioural HLSM stand-in plus a result
// scoreboard fed when each bundle is driven and drained on each handshake.

module tb_hlsm_launcher;

  localparam int DATA_W  = 16;
  localparam int NUM_OPS = 5;
  localparam int TIMEOUT = 50;
  localparam int OPS_W   = DATA_W * NUM_OPS;

  typedef struct {
    logic [15:0] data;
    logic [15:0] cycles;
    logic        err;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              opValid;
  logic              opReady;
  logic [OPS_W-1:0]  opData;
  logic              resValid;
  logic              resReady;
  logic [15:0]       resData;
  logic [15:0]       resCycles;
  logic              resErr;
  logic              hlsmStart;
  logic              hlsmRst;
  logic [OPS_W-1:0]  hlsmOps;
  logic              hlsmDone;
  logic [15:0]       hlsmResult;
  logic              busy;

  int   errorCount = 0;
  int   checkCount = 0;
  int   txCount = 0;
  int   startCycles = 0;
  int   rstCycles = 0;
  int   resValidCycles = 0;
  int   modelLat = 11;
  bit   neverDone = 1'b0;
  exp_t expQ[$];
  exp_t monExp;

  logic             mBusy;
  int               mCnt;
  logic [OPS_W-1:0] mOps;

  hlsm_launcher #(
    .DATA_W(DATA_W),
    .NUM_OPS(NUM_OPS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clock),
    .i_rst(reset),
    .i_op_valid(opValid),
    .o_op_ready(opReady),
    .i_op_data(opData),
    .o_res_valid(resValid),
    .i_res_ready(resReady),
    .o_res_data(resData),
    .o_res_cycles(resCycles),
    .o_res_err(resErr),
    .o_hlsm_start(hlsmStart),
    .o_hlsm_rst(hlsmRst),
    .o_hlsm_ops(hlsmOps),
    .i_hlsm_done(hlsmDone),
    .i_hlsm_result(hlsmResult),
    .o_busy(busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  function automatic logic [OPS_W-1:0] packOps(input int a, input int b, input int c,
                                               input int d, input int e);
    return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [15:0] opsSum(input logic [OPS_W-1:0] v);
    logic [15:0] s = 16'd0;
    for (int k = 0; k < NUM_OPS; k++) s = s + v[k*DATA_W +: DATA_W];
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // HLSM stand-in: launches on Start, raises Done modelLat cycles after the
  // launch edge and keeps Done high until it is relaunched or reset.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mBusy      <= 1'b0;
      mCnt       <= 0;
      mOps       <= '0;
      hlsmDone   <= 1'b0;
      hlsmResult <= '0;
    end else if (hlsmRst) begin
      mBusy    <= 1'b0;
      hlsmDone <= 1'b0;
    end else if (!mBusy && hlsmStart) begin
      mBusy    <= 1'b1;
      mCnt     <= 0;
      mOps     <= hlsmOps;
      hlsmDone <= 1'b0;
    end else if (mBusy) begin
      mCnt <= mCnt + 1;
      if (!neverDone && (mCnt + 1 == modelLat)) begin
        hlsmDone   <= 1'b1;
        hlsmResult <= opsSum(mOps);
        mBusy      <= 1'b0;
      end
    end
  end

  // Output monitor: activity counters and scoreboard drain on each handshake.
  always @(negedge clock) begin
    if (hlsmStart) startCycles++;
    if (hlsmRst) rstCycles++;
    if (resValid) resValidCycles++;
    if (!reset && resValid && resReady) begin
      txCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected result", 32'd1, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("res_data", 32'(resData), 32'(monExp.data));
        checkOutput("res_cycles", 32'(resCycles), 32'(monExp.cycles));
        checkOutput("res_err", 32'(resErr), 32'(monExp.err));
      end
    end
  end

  // Drives one bundle, waits (bounded) for acceptance and checks the launch.
  task automatic applyStimulus(input logic [OPS_W-1:0] data, input int lat,
                               input logic [15:0] expData, input logic [15:0] expCyc,
                               input logic expErr, input bit expectResult);
    exp_t e;
    bit   accepted = 1'b0;
    modelLat = lat;
    if (expectResult) begin
      e.data   = expData;
      e.cycles = expCyc;
      e.err    = expErr;
      expQ.push_back(e);
    end
    @(posedge clock); #1;
    opValid = 1'b1;
    opData  = data;
    for (int n = 0; n < 50 && !accepted; n++) begin
      accepted = opReady;
      @(posedge clock); #1;
    end
    opValid = 1'b0;
    checkOutput("bundle accepted", 32'(accepted), 32'd1);
    checkOutput("start in ARM", 32'(hlsmStart), 32'd1);
    checkOutput("op_ready in ARM", 32'(opReady), 32'd0);
    checkOutput("busy in ARM", 32'(busy), 32'd1);
    checkOutput("ops latched", 32'(hlsmOps == data), 32'd1);
  endtask

  task automatic waitDrain(input int bound);
    for (int n = 0; n < bound && expQ.size() != 0; n++) @(negedge clock);
    checkOutput("queue drained", 32'(expQ.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    reset    = 1'b1;
    opValid  = 1'b0;
    opData   = '0;
    resReady = 1'b1;

    #12;
    checkOutput("rst op_ready", 32'(opReady), 32'd1);
    checkOutput("rst res_valid", 32'(resValid), 32'd0);
    checkOutput("rst res_data", 32'(resData), 32'd0);
    checkOutput("rst res_cycles", 32'(resCycles), 32'd0);
    checkOutput("rst res_err", 32'(resErr), 32'd0);
    checkOutput("rst hlsm_start", 32'(hlsmStart), 32'd0);
    checkOutput("rst hlsm_rst", 32'(hlsmRst), 32'd0);
    checkOutput("rst hlsm_ops", 32'(hlsmOps == '0), 32'd1);
    checkOutput("rst busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Single run: Done 11 cycles after launch.
    $display("[TB] single run");
    startCycles = 0;
    applyStimulus(packOps(1, 2, 3, 4, 5), 11, 16'd15, 16'd13, 1'b0, 1'b1);
    waitDrain(100);
    checkOutput("single start cycles", 32'(startCycles), 32'd12);
    checkOutput("single tx count", 32'(txCount), 32'd1);

    // Stale Done from the previous run must not short-circuit the next one.
    $display("[TB] stale done");
    applyStimulus(packOps(-7, 0, 0, 0, 0), 3, 16'hFFF9, 16'd5, 1'b0, 1'b1);
    waitDrain(100);
    checkOutput("done still high", 32'(hlsmDone), 32'd1);
    applyStimulus(packOps(100, 1, 1, 1, 1), 3, 16'd104, 16'd5, 1'b0, 1'b1);
    waitDrain(100);
    checkOutput("stale tx count", 32'(txCount), 32'd3);

    // Back-pressure: result held, new bundle refused.
    $display("[TB] back-pressure");
    resReady = 1'b0;
    applyStimulus(packOps(10, 20, 30, 40, 50), 2, 16'd150, 16'd4, 1'b0, 1'b1);
    for (int n = 0; n < 50 && !resValid; n++) @(negedge clock);
    checkOutput("bp res_valid", 32'(resValid), 32'd1);
    opValid = 1'b1;
    opData  = packOps(9, 9, 9, 9, 9);
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      checkOutput("bp res_data", 32'(resData), 32'd150);
      checkOutput("bp op_ready", 32'(opReady), 32'd0);
    end
    checkOutput("bp ops held", 32'(hlsmOps == packOps(10, 20, 30, 40, 50)), 32'd1);
    @(posedge clock); #1;
    opValid  = 1'b0;
    resReady = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("op_ready after tx", 32'(opReady), 32'd1);
    checkOutput("bp queue empty", 32'(expQ.size()), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    $display("[TB] reset mid-WAIT");
    applyStimulus(packOps(5, 5, 5, 5, 5), 100, 16'd0, 16'd0, 1'b0, 1'b0);
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async start", 32'(hlsmStart), 32'd0);
    checkOutput("async busy", 32'(busy), 32'd0);
    checkOutput("async op_ready", 32'(opReady), 32'd1);
    checkOutput("async res_cycles", 32'(resCycles), 32'd0);
    checkOutput("async ops", 32'(hlsmOps == '0), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    resValidCycles = 0;
    repeat (150) @(negedge clock);
    checkOutput("aborted res_valid", 32'(resValidCycles), 32'd0);

`ifdef HLSM_LAUNCHER_TIMEOUT_EN
    // Watchdog: core never finishes.
    $display("[TB] watchdog timeout");
    startCycles = 0;
    rstCycles   = 0;
    neverDone   = 1'b1;
    applyStimulus(packOps(3, 3, 3, 3, 3), 1, 16'd0, 16'd51, 1'b1, 1'b1);
    waitDrain(200);
    checkOutput("timeout start cycles", 32'(startCycles), 32'd51);
    checkOutput("timeout rst pulse", 32'(rstCycles), 32'd1);
    neverDone = 1'b0;
    applyStimulus(packOps(1, 2, 3, 4, -5), 4, 16'd5, 16'd6, 1'b0, 1'b1);
    waitDrain(100);
    checkOutput("after timeout rst", 32'(rstCycles), 32'd1);
    checkOutput("final tx count", 32'(txCount), 32'd6);
`else
    // No watchdog: a very slow core is simply waited for.
    $display("[TB] long run without watchdog");
    startCycles = 0;
    rstCycles   = 0;
    applyStimulus(packOps(1, 1, 1, 1, 1), 1999, 16'd5, 16'd2001, 1'b0, 1'b1);
    waitDrain(2200);
    checkOutput("long start cycles", 32'(startCycles), 32'd2000);
    checkOutput("long no hlsm_rst", 32'(rstCycles), 32'd0);
    checkOutput("final tx count", 32'(txCount), 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
